// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_pkg                                                   |
// | Brief    : Shared widths, reset PC and fetch FSM state encoding.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 16;
  localparam int PC_RESET = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_reg                                                    |
// | Brief    : Program counter with clear > increment/load priority.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pc_reg #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_pc,
  input  logic              load_pc,
  input  logic              pc_sel,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] r_pc;

  // Increment relies on natural modulo-2^ADDR_W wrap.
  always_ff @(posedge clk) begin
    if (rst || clear_pc) begin
      r_pc <= ADDR_W'(PC_RESET);
    end else if (load_pc) begin
      r_pc <= pc_sel ? (r_pc + ADDR_W'(1)) : target;
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_unit                                                |
// | Brief    : PC/DAR/IR front-end with memory read handshake.           |
// |            Define FETCH_TIMEOUT_EN to enable the WAIT-state timeout  |
// |            and the sticky fetch_err flag.                            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_pc,
  input  logic               clear_pc,
  input  logic               pc_sel,
  input  logic               load_ir,
  input  logic               sel_addr,
  input  logic               load_addr,
  input  logic [INSTR_W-1:0] datapath_out,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               busy,
  output logic               fetch_err
);
  import cpu_pkg::*;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  r_dar;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_ir;
  logic               r_ir_valid;
  logic               w_accept;
  logic               w_capture;
  logic               w_timeout;
  logic               w_unused_dp;

  assign w_target    = datapath_out[ADDR_W-1:0];
  assign w_unused_dp = ^datapath_out[INSTR_W-1:ADDR_W];

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .clear_pc (clear_pc),
    .load_pc  (load_pc),
    .pc_sel   (pc_sel),
    .target   (w_target),
    .pc       (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_ir) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The address is frozen at acceptance so later PC/DAR writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dar      <= '0;
      r_mem_addr <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      if (load_addr) begin
        r_dar <= w_target;
      end
      if (w_accept) begin
        r_mem_addr <= sel_addr ? w_pc : r_dar;
      end
      if (w_capture) begin
        r_ir <= mem_rdata;
      end
      r_ir_valid <= w_capture;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_fetch_err;

  // A response arriving on the final cycle still wins over the timeout.
  assign w_timeout = (r_state == WAIT) && !mem_rvalid &&
                     (r_wait_cnt == c_cnt_w'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end else if (clear_pc) begin
        r_fetch_err <= 1'b0;
      end
    end
  end

  assign fetch_err = r_fetch_err;
`else
  localparam int c_unused_timeout = TIMEOUT;

  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign mem_rd_req = (r_state == REQ);
  assign busy       = (r_state != IDLE);
  assign mem_addr   = r_mem_addr;
  assign pc         = w_pc;
  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                             |
// | Brief    : Directed plus randomized checks of fetch_unit.            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int AW  = 8;
  localparam int IW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_pc;
  logic          clear_pc;
  logic          pc_sel;
  logic          load_ir;
  logic          sel_addr;
  logic          load_addr;
  logic [IW-1:0] datapath_out;
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic          busy;
  logic          fetch_err;

  int            total = 0;
  int            bad   = 0;
  int            m_pc;
  int            m_dar;
  logic [IW-1:0] m_ir;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_pc      (load_pc),
    .clear_pc     (clear_pc),
    .pc_sel       (pc_sel),
    .load_ir      (load_ir),
    .sel_addr     (sel_addr),
    .load_addr    (load_addr),
    .datapath_out (datapath_out),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .pc           (pc),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .fetch_err    (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    load_pc      = 1'b0;
    clear_pc     = 1'b0;
    pc_sel       = 1'b0;
    load_ir      = 1'b0;
    sel_addr     = 1'b0;
    load_addr    = 1'b0;
    datapath_out = '0;
    mem_rdata    = '0;
    mem_rvalid   = 1'b0;
  endtask

  task automatic noise();
    clear_pc     = ($urandom_range(5) == 0);
    load_pc      = ($urandom_range(1) != 0);
    pc_sel       = ($urandom_range(1) != 0);
    load_addr    = ($urandom_range(1) != 0);
    datapath_out = 16'($urandom);
  endtask

  // One clock: reference PC/DAR follow the architectural update rules.
  task automatic cycle();
    int npc;
    int ndar;
    npc  = m_pc;
    ndar = m_dar;
    if (rst) begin
      npc  = 0;
      ndar = 0;
    end else begin
      if (clear_pc)     npc = 0;
      else if (load_pc) npc = pc_sel ? (m_pc + 1) % 256 : int'(datapath_out) & 255;
      if (load_addr)    ndar = int'(datapath_out) & 255;
    end
    @(posedge clk);
    #1;
    m_pc  = npc;
    m_dar = ndar;
    chk("pc", pc, m_pc);
  endtask

  task automatic do_fetch(input logic sel, input int lat, input logic [IW-1:0] data,
                          input bit noisy);
    int exp_addr;
    if (noisy) noise();
    load_ir  = 1'b1;
    sel_addr = sel;
    exp_addr = sel ? m_pc : m_dar;
    cycle();
    chk("req_pulse", mem_rd_req, 1);
    chk("busy_req", busy, 1);
    chk("mem_addr", mem_addr, exp_addr);
    for (int k = 1; k <= lat; k++) begin
      if (noisy) noise();
      mem_rvalid = (k == 1) ? ($urandom_range(1) != 0) : 1'b0;
      mem_rdata  = 16'($urandom);
      cycle();
      chk("no_extra_req", mem_rd_req, 0);
      chk("busy_wait", busy, 1);
      chk("no_early_valid", ir_valid, 0);
      chk("ir_hold_wait", ir, m_ir);
      chk("addr_stable", mem_addr, exp_addr);
    end
    if (noisy) noise();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    cycle();
    m_ir = data;
    chk("ir_data", ir, m_ir);
    chk("ir_valid", ir_valid, 1);
    chk("busy_done", busy, 0);
    load_ir    = 1'b0;
    mem_rvalid = ($urandom_range(1) != 0);
    mem_rdata  = 16'($urandom);
    cycle();
    mem_rvalid = 1'b0;
    chk("valid_once", ir_valid, 0);
    chk("ir_hold_idle", ir, m_ir);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    quiet();
    rst   = 1'b1;
    m_pc  = 0;
    m_dar = 0;
    m_ir  = '0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_ir", ir, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", fetch_err, 0);

    // Latency-1 fetch from PC 0.
    do_fetch(1'b1, 1, 16'hD0A5, 1'b0);
    chk("t1_ir", ir, 16'hD0A5);

    // PC wrap, then clear beats load.
    quiet();
    load_pc      = 1'b1;
    datapath_out = 16'h00FF;
    cycle();
    pc_sel = 1'b1;
    cycle();
    chk("pc_wrap", pc, 8'h00);
    clear_pc     = 1'b1;
    pc_sel       = 1'b0;
    datapath_out = 16'h0042;
    cycle();
    chk("pc_clear_wins", pc, 8'h00);

    // DAR-addressed fetch, latency 4, load_ir held during busy.
    quiet();
    load_addr    = 1'b1;
    datapath_out = 16'h0037;
    cycle();
    load_addr = 1'b0;
    do_fetch(1'b0, 4, 16'h5A3C, 1'b0);
    chk("dar_addr_seen", mem_addr, 8'h37);

    // Reset while in WAIT; late response must be dropped.
    quiet();
    load_ir  = 1'b1;
    sel_addr = 1'b1;
    cycle();
    load_ir = 1'b0;
    cycle();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    cycle();
    rst  = 1'b0;
    m_ir = '0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    cycle();
    mem_rvalid = 1'b0;
    chk("late_ir", ir, 0);
    chk("late_valid", ir_valid, 0);
    chk("late_busy", busy, 0);
    cycle();
    chk("late_valid2", ir_valid, 0);
    chk("late_ir2", ir, 0);
    do_fetch(1'b1, 2, 16'h1357, 1'b0);

    // Randomized traffic with PC/DAR activity during fetches.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(2)) begin
        noise();
        load_ir = 1'b0;
        cycle();
      end
      do_fetch($urandom_range(1) != 0, $urandom_range(5, 1), 16'($urandom), 1'b1);
      chk("err_clear_run", fetch_err, 0);
    end

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: error after TMO WAIT cycles.
    quiet();
    load_ir  = 1'b1;
    sel_addr = 1'b1;
    cycle();
    load_ir = 1'b0;
    chk("tmo_req", mem_rd_req, 1);
    cycle();
    for (int i = 2; i <= TMO + 1; i++) begin
      chk("tmo_busy", busy, 1);
      chk("tmo_err_early", fetch_err, 0);
      cycle();
    end
    chk("tmo_err", fetch_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_valid", ir_valid, 0);
    chk("tmo_ir_hold", ir, m_ir);
    cycle();
    chk("tmo_sticky", fetch_err, 1);
    clear_pc = 1'b1;
    cycle();
    clear_pc = 1'b0;
    chk("tmo_cleared", fetch_err, 0);
`else
    quiet();
    load_ir  = 1'b1;
    sel_addr = 1'b1;
    cycle();
    load_ir = 1'b0;
    repeat (TMO + 3) cycle();
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_err", fetch_err, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction/data address front-end for the 16-bit RISC CPU.
- Sits directly upstream of the controller and consumes its strobes: load_pc, clear_pc, load_ir, pc_sel, sel_addr, load_addr.
- Owns the program counter, the data address register and the instruction register.
- Runs the read handshake with instruction/data memory and returns a fetched instruction to the controller with an ir_valid pulse.

Parameters:
- ADDR_W, 8, memory address / PC width.
- INSTR_W, 16, instruction and memory data width.
- TIMEOUT, 15, WAIT cycles before fetch_err; used only with the optional feature.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_pc  in  1  controller strobe: update PC.
- clear_pc  in  1  controller strobe: PC to 0.
- pc_sel  in  1  1 = PC+1, 0 = branch target from datapath_out.
- load_ir  in  1  controller strobe: start an instruction fetch.
- sel_addr  in  1  1 = memory address from PC, 0 = from DAR.
- load_addr  in  1  load DAR from datapath_out.
- datapath_out  in  INSTR_W  datapath result; low ADDR_W bits used.
- mem_rd_req  out  1  one-cycle read request.
- mem_addr  out  ADDR_W  read address; registered at request.
- mem_rdata  in  INSTR_W  read data.
- mem_rvalid  in  1  read data valid; earliest one cycle after mem_rd_req.
- pc  out  ADDR_W  current PC.
- ir  out  INSTR_W  instruction register.
- ir_valid  out  1  one-cycle pulse when ir is updated.
- busy  out  1  fetch outstanding.
- fetch_err  out  1  sticky fetch timeout; tied 0 without the optional feature.

Behaviour:
- Reset: all outputs 0; pc=0, dar=0, ir=0; FSM to IDLE.
- Reset mid-fetch abandons the fetch; a late mem_rvalid after reset is ignored.
- PC update, in priority order:
  - clear_pc: pc <= 0.
  - else load_pc with pc_sel=1: pc <= pc+1, wrapping 8'hFF to 8'h00.
  - else load_pc with pc_sel=0: pc <= datapath_out[ADDR_W-1:0].
- DAR: load_addr loads dar <= datapath_out[ADDR_W-1:0].
- Address select: sel_addr ? pc : dar, sampled in the cycle load_ir is accepted.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: load_ir=1 goes to REQ and latches mem_addr from the address select.
  - REQ: mem_rd_req=1 for exactly one cycle; always goes to WAIT.
  - WAIT: on mem_rvalid, ir <= mem_rdata and ir_valid=1 on the next cycle; returns to IDLE.
- busy=1 in REQ and WAIT.
- load_ir while busy is ignored; no queueing.
- mem_rvalid in IDLE or REQ is ignored.
- PC/DAR updates during a fetch are allowed and do not alter the latched mem_addr.
- Latency: load_ir at cycle t gives mem_rd_req at t+1. A memory with latency L (rvalid at t+1+L) gives ir/ir_valid at t+2+L.
- ir holds its value until the next completed fetch.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and is cleared on entry.
  - At TIMEOUT cycles without mem_rvalid: fetch_err <= 1 (sticky), ir unchanged, no ir_valid, FSM to IDLE.
  - fetch_err clears on rst or clear_pc.
- Undefined: WAIT waits indefinitely; fetch_err constant 0; no counter logic.

Decomposition:
- Package cpu_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT).
  - ADDR_W and INSTR_W constants.
  - PC_RESET = 0.
  - Shared by the controller and the datapath.
- Sub-module pc_reg:
  - Holds PC with clear/increment/load priority.
  - Instantiated once; DAR and IR stay inline.

Test Plan:
- Reset, then load_ir with sel_addr=1, memory latency 1 returning 16'hD0A5 -> mem_addr=0, mem_rd_req one cycle, ir=16'hD0A5 with one ir_valid pulse 3 cycles after load_ir.
- pc=8'hFF, load_pc=1, pc_sel=1 -> pc=8'h00. Then clear_pc and load_pc together with pc_sel=0 and datapath_out=16'h0042 -> pc=0 (clear wins).
- load_addr with datapath_out=16'h0037, then load_ir with sel_addr=0, latency 4 -> mem_addr=8'h37, busy high 5 cycles; a second load_ir during busy produces no extra mem_rd_req.
- Assert rst in WAIT, then mem_rvalid one cycle later with 16'hBEEF -> ir stays 0, ir_valid never pulses, FSM in IDLE.
- FETCH_TIMEOUT_EN, TIMEOUT=15, memory never responds -> fetch_err=1 after 15 WAIT cycles, busy=0; then clear_pc -> fetch_err=0.
